prim_esc_sender: RTL and testbench

PRIM_ESC_SENDER -- requirements
Module: prim_esc_sender

---
 rtl/prim_esc_pkg.sv | 38 +++
 rtl/prim_esc_sender.sv | 135 +++++++++++++
 tb/tb_prim_esc_sender.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/prim_esc_pkg.sv
// Shared types for the escalation sender: FSM state encoding, the differential
// line structs, and the expected receiver response for each checking state.
package prim_esc_pkg;

  typedef enum logic [3:0] {
    Idle,
    PingArm,
    Ping0,
    Ping1,
    Ping2,
    Ping3,
    EscArm,
    EscHi,
    EscLo,
    EscResync
  } esc_state_e;

  typedef struct packed {
    logic esc_p;
    logic esc_n;
  } esc_tx_t;

  typedef struct packed {
    logic resp_p;
    logic resp_n;
  } esc_rx_t;

  // Level the receiver must present on resp_p while the sender sits in state s
  function automatic logic exp_resp(esc_state_e s);
    logic r;
    case (s)
      Ping0, Ping2, EscHi: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prim_esc_sender.sv
// Escalation sender: differential esc line, ping handshake and response checking.
// Define ESC_SENDER_INTEG_LATCH_EN to make integ_fail_o sticky until reset.
module prim_esc_sender
  import prim_esc_pkg::*;
#(
  parameter int ResyncCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ping_en_i,
  input  logic       esc_en_i,
  input  logic [1:0] esc_rx_i,
  output logic [1:0] esc_tx_o,
  output logic       ping_ok_o,
  output logic       integ_fail_o
);

  localparam int CntW = (ResyncCycles > 2) ? $clog2(ResyncCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ResyncCycles - 1);

  esc_state_e     state_q, state_d;
  logic           esc_p_q, ping_en_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           ping_edge, sigint, mismatch;
  logic           ping_ok, integ_det;
  esc_tx_t        esc_tx;
  esc_rx_t        esc_rx;

  assign esc_rx    = esc_rx_i;
  assign esc_tx    = '{esc_p: esc_p_q, esc_n: ~esc_p_q};
  assign esc_tx_o  = esc_tx;
  assign ping_edge = ping_en_i & ~ping_en_q;
  assign sigint    = (esc_rx.resp_p == esc_rx.resp_n);
  assign mismatch  = (esc_rx.resp_p != exp_resp(state_q));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      esc_p_q   <= 1'b0;
      ping_en_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      esc_p_q   <= esc_en_i | ping_edge;
      ping_en_q <= ping_en_i;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    ping_ok   = 1'b0;
    integ_det = 1'b0;
    case (state_q)
      Idle: begin
        if (esc_rx.resp_p) begin
          integ_det = 1'b1;
        end else if (esc_en_i) begin
          state_d = EscArm;
        end else if (ping_edge) begin
          state_d = PingArm;
        end
      end
      PingArm, Ping0, Ping1, Ping2, Ping3: begin
        // Escalation pre-empts the ping; the receiver may be mid-pattern, so skip the check
        if (esc_en_i) begin
          state_d = EscResync;
        end else if (mismatch) begin
          integ_det = 1'b1;
          state_d   = Idle;
        end else begin
          case (state_q)
            PingArm: state_d = Ping0;
            Ping0:   state_d = Ping1;
            Ping1:   state_d = Ping2;
            Ping2:   state_d = Ping3;
            default: begin
              state_d = Idle;
              ping_ok = 1'b1;
            end
          endcase
        end
      end
      EscArm, EscHi, EscLo: begin
        if (mismatch) begin
          integ_det = 1'b1;
          state_d   = Idle;
        end else if (state_q == EscArm) begin
          state_d = EscHi;
        end else if (!esc_p_q) begin
          state_d = Idle;
        end else begin
          state_d = (state_q == EscHi) ? EscLo : EscHi;
        end
      end
      EscResync: begin
        if (esc_rx.resp_p) begin
          state_d = EscLo;
        end else if (cnt_q == CntMax) begin
          integ_det = 1'b1;
          state_d   = Idle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = Idle;
    endcase
    // A collapsed differential pair overrides everything else
    if (sigint) begin
      integ_det = 1'b1;
      ping_ok   = 1'b0;
      state_d   = Idle;
    end
  end

  assign ping_ok_o = rst_ni & ping_ok;

`ifdef ESC_SENDER_INTEG_LATCH_EN
  logic integ_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      integ_q <= 1'b0;
    end else if (integ_det) begin
      integ_q <= 1'b1;
    end
  end

  assign integ_fail_o = rst_ni & (integ_det | integ_q);
`else
  assign integ_fail_o = rst_ni & integ_det;
`endif

endmodule

// File: tb/tb_prim_esc_sender.sv
// Randomized self-checking bench for prim_esc_sender; expectations come from
// per-cycle protocol timelines computed with plain arithmetic.
module tb_prim_esc_sender;

  localparam int R = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni, ping_en_i, esc_en_i;
  logic [1:0] esc_rx_i, esc_tx_o;
  logic       ping_ok_o, integ_fail_o;

  int checks = 0;
  int failures = 0;
  bit sticky = 1'b0;

  always #5 clk_i = ~clk_i;

  prim_esc_sender #(.ResyncCycles(R)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .ping_en_i(ping_en_i),
    .esc_en_i(esc_en_i),
    .esc_rx_i(esc_rx_i),
    .esc_tx_o(esc_tx_o),
    .ping_ok_o(ping_ok_o),
    .integ_fail_o(integ_fail_o)
  );

  // One cycle: drive inputs after the falling edge, leave outputs settled for sampling
  task automatic cyc(input bit p, input bit e, input bit [1:0] rx, input bit r);
    @(negedge clk_i);
    ping_en_i = p;
    esc_en_i  = e;
    esc_rx_i  = rx;
    rst_ni    = r;
    #1;
  endtask

  // Expected integ_fail_o given whether an error is detected this cycle
  task automatic model_integ(input bit det, output bit exp_v);
`ifdef ESC_SENDER_INTEG_LATCH_EN
    exp_v  = det | sticky;
    sticky = sticky | det;
`else
    exp_v = det;
`endif
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b0);
    sticky = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 2'b11, 1'b0);
    cyc(1'b0, 1'b0, 2'b11, 1'b0);
    checks += 3;
    if (esc_tx_o !== 2'b01) begin failures++; $display("FAIL reset_esc_tx got=%b exp=01", esc_tx_o); end
    if (ping_ok_o !== 1'b0) begin failures++; $display("FAIL reset_ping_ok got=%b exp=0", ping_ok_o); end
    if (integ_fail_o !== 1'b0) begin failures++; $display("FAIL reset_integ got=%b exp=0", integ_fail_o); end
    cyc(1'b0, 1'b1, 2'b01, 1'b1);  // Idle, escalation requested
    cyc(1'b0, 1'b1, 2'b01, 1'b1);  // EscArm
    checks++;
    if (esc_tx_o !== 2'b10) begin failures++; $display("FAIL rst_esc_arm_tx got=%b exp=10", esc_tx_o); end
    cyc(1'b0, 1'b1, 2'b10, 1'b1);  // EscHi
    cyc(1'b0, 1'b0, 2'b11, 1'b0);  // EscLo with reset and a collapsed pair
    checks += 3;
    if (esc_tx_o !== 2'b10) begin failures++; $display("FAIL rst_esclo_tx got=%b exp=10", esc_tx_o); end
    if (ping_ok_o !== 1'b0) begin failures++; $display("FAIL rst_esclo_ping_ok got=%b exp=0", ping_ok_o); end
    if (integ_fail_o !== 1'b0) begin failures++; $display("FAIL rst_esclo_integ got=%b exp=0", integ_fail_o); end
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, 2'b01, 1'b1);
      checks += 3;
      if (esc_tx_o !== 2'b01) begin failures++; $display("FAIL rst_after_tx c=%0d got=%b exp=01", c, esc_tx_o); end
      if (ping_ok_o !== 1'b0) begin failures++; $display("FAIL rst_after_ping_ok c=%0d got=%b exp=0", c, ping_ok_o); end
      if (integ_fail_o !== 1'b0) begin failures++; $display("FAIL rst_after_integ c=%0d got=%b exp=0", c, integ_fail_o); end
    end
    sticky = 1'b0;
    $display("reset: escalation interrupted in EscLo");
  endtask

  task automatic test_sigint();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bit [1:0] rx;
      bit det, ei;
      rx = (c == 0) ? 2'b11 : (c == 1) ? 2'b01 : 2'($urandom_range(0, 3));
      det = (rx != 2'b01);  // anything but a clean low response is an error in Idle
      cyc(1'b0, 1'b0, rx, 1'b1);
      model_integ(det, ei);
      checks += 3;
      if (integ_fail_o !== ei) begin failures++; $display("FAIL sigint_integ c=%0d rx=%b got=%b exp=%b", c, rx, integ_fail_o, ei); end
      if (ping_ok_o !== 1'b0) begin failures++; $display("FAIL sigint_ping_ok c=%0d got=%b exp=0", c, ping_ok_o); end
      if (esc_tx_o !== 2'b01) begin failures++; $display("FAIL sigint_tx c=%0d got=%b exp=01", c, esc_tx_o); end
    end
    $display("sigint: idle rail errors");
  endtask

  // Ping with optional receiver fault f, extra ping edge at r (6 = back-to-back ping)
  task automatic test_ping();
    for (int it = 0; it < 10; it++) begin
      int f, r, s2, tmp;
      f = (it == 0) ? 0 : int'($urandom_range(0, 5));
      tmp = int'($urandom_range(0, 5));
      r = (f != 0 || tmp == 0) ? 0 : tmp + 1;
      s2 = (r == 6) ? 6 : -100;
      do_reset();
      for (int c = 0; c <= 12; c++) begin
        bit p, resp, ep, eok, det, ei;
        p = (c == 0) || (r != 0 && c >= r);
        resp = (c == 2 || c == 4 || c == s2 + 2 || c == s2 + 4);
        if (f != 0 && c == f) resp = ~resp;
        else if (f != 0 && c > f) resp = 1'b0;
        ep = (c == 1) || (r != 0 && c == r + 1);
        eok = (f == 0) && (c == 5 || c == s2 + 5);
        det = (f != 0 && c == f);
        cyc(p, 1'b0, {resp, ~resp}, 1'b1);
        model_integ(det, ei);
        checks += 3;
        if (esc_tx_o !== (ep ? 2'b10 : 2'b01)) begin failures++; $display("FAIL ping_tx c=%0d f=%0d r=%0d got=%b exp_p=%b", c, f, r, esc_tx_o, ep); end
        if (ping_ok_o !== eok) begin failures++; $display("FAIL ping_ok c=%0d f=%0d r=%0d got=%b exp=%b", c, f, r, ping_ok_o, eok); end
        if (integ_fail_o !== ei) begin failures++; $display("FAIL ping_integ c=%0d f=%0d r=%0d got=%b exp=%b", c, f, r, integ_fail_o, ei); end
      end
      $display("ping: fault_cycle=%0d extra_edge=%0d", f, r);
    end
  endtask

  // Escalation held n cycles against a compliant receiver
  task automatic test_escalation();
    for (int it = 0; it < 6; it++) begin
      int n;
      n = (it == 0) ? 6 : int'($urandom_range(1, 8));
      do_reset();
      for (int c = 0; c <= n + 3; c++) begin
        bit e, resp, ep;
        e = (c < n);
        resp = (c >= 2 && c <= n + 1 && (c % 2) == 0);
        ep = (c >= 1 && c <= n);
        cyc(1'b0, e, {resp, ~resp}, 1'b1);
        checks += 3;
        if (esc_tx_o !== (ep ? 2'b10 : 2'b01)) begin failures++; $display("FAIL esc_tx c=%0d n=%0d got=%b exp_p=%b", c, n, esc_tx_o, ep); end
        if (integ_fail_o !== 1'b0) begin failures++; $display("FAIL esc_integ c=%0d n=%0d got=%b exp=0", c, n, integ_fail_o); end
        if (ping_ok_o !== 1'b0) begin failures++; $display("FAIL esc_ping_ok c=%0d n=%0d got=%b exp=0", c, n, ping_ok_o); end
      end
      $display("escalation: held %0d cycles", n);
    end
  endtask

  // Escalation against a receiver stuck low: every arm attempt fails in its EscHi cycle
  task automatic test_silent();
    for (int it = 0; it < 4; it++) begin
      int n;
      n = (it == 0) ? 2 : int'($urandom_range(1, 8));
      do_reset();
      for (int c = 0; c <= n + 4; c++) begin
        bit e, ep, det, ei;
        e = (c < n);
        ep = (c >= 1 && c <= n);
        det = (c >= 2) && ((c - 2) % 3 == 0) && ((c - 2) <= n - 1);
        cyc(1'b0, e, 2'b01, 1'b1);
        model_integ(det, ei);
        checks += 2;
        if (esc_tx_o !== (ep ? 2'b10 : 2'b01)) begin failures++; $display("FAIL silent_tx c=%0d n=%0d got=%b exp_p=%b", c, n, esc_tx_o, ep); end
        if (integ_fail_o !== ei) begin failures++; $display("FAIL silent_integ c=%0d n=%0d got=%b exp=%b", c, n, integ_fail_o, ei); end
      end
      $display("silent: escalation held %0d cycles", n);
    end
  endtask

  // Escalation lands in Ping1; receiver realigns after d cycles (d == R never realigns)
  task automatic test_resync();
    for (int d = 0; d <= R; d++) begin
      int h, e_end;
      bit timeout;
      timeout = (d == R);
      h = int'($urandom_range(1, 4));
      e_end = timeout ? 3 + R : 5 + d + h;
      do_reset();
      for (int c = 0; c <= e_end + 3; c++) begin
        bit p, e, resp, ep, det, ei;
        p = (c == 0);
        e = (c >= 3 && c < e_end);
        if (timeout) resp = (c == 2);
        else resp = (c == 2) || (c >= 4 + d && c <= e_end + 1 && ((c - 4 - d) % 2) == 0);
        ep = (c == 1) || (c >= 4 && c <= e_end);
        det = timeout && (c == 3 + R);
        cyc(p, e, {resp, ~resp}, 1'b1);
        model_integ(det, ei);
        checks += 3;
        if (esc_tx_o !== (ep ? 2'b10 : 2'b01)) begin failures++; $display("FAIL resync_tx c=%0d d=%0d got=%b exp_p=%b", c, d, esc_tx_o, ep); end
        if (ping_ok_o !== 1'b0) begin failures++; $display("FAIL resync_ping_ok c=%0d d=%0d got=%b exp=0", c, d, ping_ok_o); end
        if (integ_fail_o !== ei) begin failures++; $display("FAIL resync_integ c=%0d d=%0d got=%b exp=%b", c, d, integ_fail_o, ei); end
      end
      $display("resync: align_delay=%0d hold=%0d timeout=%0d", d, h, timeout);
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    ping_en_i = 1'b0;
    esc_en_i  = 1'b0;
    esc_rx_i  = 2'b01;
    test_reset();
    test_sigint();
    test_ping();
    test_escalation();
    test_silent();
    test_resync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
